x2p_apb_master: RTL and testbench
=================================

X2P_APB_MASTER -- requirements
Module: x2p_apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH_APB, default 32, APB data width; pstrb width DATA_WIDTH_APB/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS wait-cycle limit; used only with X2P_APB_TIMEOUT_EN.
REQ-004 SHALL have ports (one clock; reset asynchronous, active-high):
  pclk  in  1  clock, all state on rising edge
  preset  in  1  asynchronous active-high reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_addr  in  ADDR_WIDTH  transfer address
  cmd_write  in  1  1=write, 0=read
  cmd_wdata  in  DATA_WIDTH_APB  write data
  cmd_strb  in  DATA_WIDTH_APB/8  write byte strobes
  cmd_prot  in  3  protection attributes
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed when high with rsp_valid
  rsp_rdata  out  DATA_WIDTH_APB  read data (0 for writes)
  rsp_slverr  out  1  transfer error
  rsp_timeout  out  1  transfer aborted by timeout
  psel, penable, pwrite  out  1 each  APB control
  paddr  out  ADDR_WIDTH;  pwdata  out  DATA_WIDTH_APB;  pstrb  out  DATA_WIDTH_APB/8;  pprot  out  3
  pready  in  1;  prdata  in  DATA_WIDTH_APB;  pslverr  in  1  APB completer response

Function
REQ-005 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; all outputs SHALL be registered or decoded from state only.
REQ-006 cmd_ready SHALL be high in IDLE, and in RESP while rsp_ready is high; low otherwise.
REQ-007 On cmd_valid&cmd_ready: capture command into paddr/pwrite/pwdata/pstrb/pprot; next state SETUP.
REQ-008 For reads, pwdata and pstrb SHALL be driven 0.
REQ-009 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-010 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb/pprot SHALL remain stable until exit.
REQ-011 ACCESS with pready=1: capture rsp_rdata=prdata (reads) or 0 (writes), rsp_slverr=pslverr, rsp_timeout=0; next RESP.
REQ-012 RESP: rsp_valid=1, psel=penable=0; rsp_* SHALL hold until rsp_ready.
REQ-013 RESP with rsp_ready: next SETUP if cmd_valid (back-to-back, no IDLE cycle), else IDLE.
REQ-014 Latency: command accepted cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 when pready=1 in N+2; each pready-low cycle adds one.
REQ-015 In IDLE, psel=penable=0; paddr/pwrite/pprot SHALL hold last values.
REQ-016 cmd_* inputs SHALL be ignored outside the accepting cycle.

Reset
REQ-017 preset high SHALL immediately force IDLE: psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout = 0; paddr, pwdata, pstrb, pprot, rsp_rdata = 0; cmd_ready = 1 after release.
REQ-018 Reset mid-transfer SHALL drop the in-flight command without response; psel deasserts asynchronously.

Configuration
REQ-019 Macro X2P_APB_TIMEOUT_EN defined: counter of consecutive ACCESS cycles with pready=0; at TIMEOUT_CYCLES such cycles, next state RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; psel/penable drop; counter clears on SETUP entry.
REQ-020 Macro undefined: no counter; ACCESS waits indefinitely; rsp_timeout tied 0.

Verification
REQ-021 Read 0x04, pready=1 immediately, prdata=0x0000_1000 -> psel cycles N+1..N+2, penable N+2, rsp_valid N+3, rsp_rdata=0x0000_1000, rsp_slverr=0.
REQ-022 Write 0x08, wdata=0xDEAD_BEEF, strb=0xF, pready low 3 cycles, pslverr=1 -> ACCESS 4 cycles, address/data stable, rsp_slverr=1, rsp_rdata=0.
REQ-023 Two reads queued, rsp_ready=1 in RESP -> second SETUP directly after first RESP, no IDLE cycle.
REQ-024 rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_* held, cmd_ready=0, psel=0.
REQ-025 preset asserted during ACCESS -> psel/penable/rsp_valid 0 same cycle; after release, new read completes normally.
REQ-026 X2P_APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_slverr=1, rsp_timeout=1; undefined -> psel stays high.

Source files
------------

// File: rtl/x2p_apb_master_if.sv
// Command/response and APB bus bundle for x2p_apb_master.
// The master modport is the bridge's own view; slave is the surrounding environment.
interface x2p_apb_master_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH_APB = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH_APB / 8;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic                      cmd_write;
    logic [DATA_WIDTH_APB-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0]     cmd_strb;
    logic [2:0]                cmd_prot;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH_APB-1:0] rsp_rdata;
    logic                      rsp_slverr;
    logic                      rsp_timeout;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH_APB-1:0] pwdata;
    logic [STRB_WIDTH-1:0]     pstrb;
    logic [2:0]                pprot;
    logic                      pready;
    logic [DATA_WIDTH_APB-1:0] prdata;
    logic                      pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/x2p_apb_master.sv
// Single-outstanding command-to-APB bridge: IDLE -> SETUP -> ACCESS -> RESP.
// Optional ACCESS wait-cycle timeout enabled by defining X2P_APB_TIMEOUT_EN.
module x2p_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH_APB = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              pclk,
    input logic              preset,
    x2p_apb_master_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH_APB / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                    state_q,  state_d;
    logic [ADDR_WIDTH-1:0]     paddr_q,  paddr_d;
    logic                      pwrite_q, pwrite_d;
    logic [DATA_WIDTH_APB-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]     pstrb_q,  pstrb_d;
    logic [2:0]                pprot_q,  pprot_d;
    logic [DATA_WIDTH_APB-1:0] rdata_q,  rdata_d;
    logic                      slverr_q, slverr_d;
    logic                      accept;

`ifdef X2P_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q,  timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Ready in RESP depends on rsp_ready so a new command can overlap the response handoff.
    assign bus.cmd_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
`ifdef X2P_APB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    rdata_d  = pwrite_q ? '0 : bus.prdata;
                    slverr_d = bus.pslverr;
`ifdef X2P_APB_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d  = RESP;
                end
`ifdef X2P_APB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) state_d = accept ? SETUP : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            paddr_d  = bus.cmd_addr;
            pwrite_d = bus.cmd_write;
            pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
            pprot_d  = bus.cmd_prot;
`ifdef X2P_APB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
`ifdef X2P_APB_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pprot_q  <= pprot_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
`ifdef X2P_APB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.psel       = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable    = (state_q == ACCESS);
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pstrb      = pstrb_q;
    assign bus.pprot      = pprot_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_slverr = slverr_q;
`ifdef X2P_APB_TIMEOUT_EN
    assign bus.rsp_timeout = timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_x2p_apb_master.sv
// Randomized transaction-level bench for x2p_apb_master; acts as both command source and APB completer.
// Timeout expectations follow X2P_APB_TIMEOUT_EN when defined.
module tb_x2p_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        logic [AW-1:0]   addr;
        logic            write;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] strb;
        logic [2:0]      prot;
        int unsigned     waits;
        int unsigned     rsp_delay;
        logic            b2b;
        logic [DW-1:0]   prdata;
        logic            pslverr;
    } xfer_t;

    logic pclk = 1'b0;
    logic preset;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    xfer_t q[$];

    x2p_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH_APB(DW)) bus ();

    x2p_apb_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH_APB(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .bus(bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic drive_cmd(input xfer_t t);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = t.addr;
        bus.cmd_write = t.write;
        bus.cmd_wdata = t.wdata;
        bus.cmd_strb  = t.strb;
        bus.cmd_prot  = t.prot;
    endtask

    // Junk on the command inputs while the bridge is busy must not leak into the bus.
    task automatic garbage(input logic valid);
        bus.cmd_valid = valid;
        bus.cmd_addr  = $urandom;
        bus.cmd_write = 1'($urandom);
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'($urandom);
        bus.cmd_prot  = 3'($urandom);
    endtask

    task automatic chk_bus(input string ph, input xfer_t t);
        chk({ph, "_paddr"},  bus.paddr,  t.addr);
        chk({ph, "_pwrite"}, bus.pwrite, t.write);
        chk({ph, "_pwdata"}, bus.pwdata, t.write ? t.wdata : '0);
        chk({ph, "_pstrb"},  bus.pstrb,  t.write ? t.strb : '0);
        chk({ph, "_pprot"},  bus.pprot,  t.prot);
    endtask

    task automatic run_queue();
        xfer_t t;
        logic  prev_b2b;
        prev_b2b = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            t = q[i];
            if (!prev_b2b) begin
                @(posedge pclk); #1;
                drive_cmd(t);
                bus.rsp_ready = 1'($urandom);
                @(negedge pclk);
                chk("idle_cmd_ready", bus.cmd_ready, 1'b1);
            end
            @(posedge pclk); #1;
            garbage(1'($urandom));
            bus.pready = 1'b0;
            @(negedge pclk);
            chk("setup_psel", bus.psel, 1'b1);
            chk("setup_penable", bus.penable, 1'b0);
            chk("setup_cmd_ready", bus.cmd_ready, 1'b0);
            chk_bus("setup", t);
            for (int w = 0; w <= int'(t.waits); w++) begin
                @(posedge pclk); #1;
                garbage(1'($urandom));
                bus.pready  = (w == int'(t.waits));
                bus.prdata  = (w == int'(t.waits)) ? t.prdata : DW'($urandom);
                bus.pslverr = (w == int'(t.waits)) ? t.pslverr : 1'($urandom);
                @(negedge pclk);
                chk("access_psel", bus.psel, 1'b1);
                chk("access_penable", bus.penable, 1'b1);
                chk("access_rsp_valid", bus.rsp_valid, 1'b0);
                chk_bus("access", t);
            end
            for (int d = 0; d <= int'(t.rsp_delay); d++) begin
                @(posedge pclk); #1;
                bus.pready  = 1'($urandom);
                bus.prdata  = $urandom;
                bus.pslverr = 1'($urandom);
                bus.rsp_ready = (d == int'(t.rsp_delay));
                if (d != int'(t.rsp_delay)) garbage(1'($urandom));
                else if (t.b2b && i + 1 < q.size()) drive_cmd(q[i+1]);
                else garbage(1'b0);
                @(negedge pclk);
                chk("resp_valid", bus.rsp_valid, 1'b1);
                chk("resp_rdata", bus.rsp_rdata, t.write ? '0 : t.prdata);
                chk("resp_slverr", bus.rsp_slverr, t.pslverr);
                chk("resp_timeout", bus.rsp_timeout, 1'b0);
                chk("resp_psel", {bus.psel, bus.penable}, 2'b00);
                chk("resp_cmd_ready", bus.cmd_ready, (d == int'(t.rsp_delay)));
            end
            prev_b2b = t.b2b && (i + 1 < q.size());
            if (!prev_b2b) begin
                @(posedge pclk); #1;
                garbage(1'b0);
                bus.rsp_ready = 1'($urandom);
                @(negedge pclk);
                chk("idle_psel", {bus.psel, bus.penable}, 2'b00);
                chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
                chk("idle_cmd_ready", bus.cmd_ready, 1'b1);
                chk("idle_paddr_hold", bus.paddr, t.addr);
                chk("idle_pwrite_hold", bus.pwrite, t.write);
                chk("idle_pprot_hold", bus.pprot, t.prot);
            end
        end
        q.delete();
    endtask

    function automatic xfer_t mk(input logic [AW-1:0] addr, input logic write, input logic [DW-1:0] wdata,
                                 input logic [3:0] strb, input int unsigned waits, input int unsigned rdly,
                                 input logic b2b, input logic [DW-1:0] prdata, input logic slverr);
        xfer_t t;
        t.addr = addr; t.write = write; t.wdata = wdata; t.strb = strb; t.prot = 3'($urandom);
        t.waits = waits; t.rsp_delay = rdly; t.b2b = b2b; t.prdata = prdata; t.pslverr = slverr;
        return t;
    endfunction

    task automatic reset_checks(input string ph);
        chk({ph, "_psel"}, {bus.psel, bus.penable, bus.pwrite}, 3'b000);
        chk({ph, "_rsp"}, {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b000);
        chk({ph, "_paddr"}, bus.paddr, '0);
        chk({ph, "_pwdata"}, bus.pwdata, '0);
        chk({ph, "_pstrb_pprot"}, {bus.pstrb, bus.pprot}, '0);
        chk({ph, "_rsp_rdata"}, bus.rsp_rdata, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1;
        garbage(1'b0);
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        reset_checks("reset");
        @(posedge pclk); #3;
        preset = 1'b0;
        @(negedge pclk);
        chk("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        reset_checks("post_reset");

        q.push_back(mk(32'h04, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0000_1000, 1'b0));
        q.push_back(mk(32'h08, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 0, 1'b0, 32'h1234_5678, 1'b1));
        q.push_back(mk(32'h10, 1'b0, 32'h0, 4'h0, 0, 0, 1'b1, 32'hA5A5_0001, 1'b0));
        q.push_back(mk(32'h14, 1'b0, 32'h0, 4'h0, 1, 0, 1'b0, 32'hA5A5_0002, 1'b0));
        q.push_back(mk(32'h18, 1'b0, 32'h0, 4'h0, 0, 5, 1'b0, 32'hCAFE_F00D, 1'b0));
        for (int i = 0; i < 30; i++)
            q.push_back(mk($urandom, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
                           $urandom_range(0, 3), (i != 29) && ($urandom_range(0, 1) == 1),
                           $urandom, 1'($urandom)));
        run_queue();

        // Reset in the middle of an ACCESS wait drops the transfer.
        @(posedge pclk); #1;
        drive_cmd(mk(32'h20, 1'b1, 32'h1111_2222, 4'h3, 0, 0, 1'b0, 32'h0, 1'b0));
        bus.rsp_ready = 1'b1;
        @(posedge pclk); #1;
        garbage(1'b0);
        bus.pready = 1'b0;
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("pre_reset_access", {bus.psel, bus.penable}, 2'b11);
        #2 preset = 1'b1;
        #1;
        chk("async_reset_psel", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
        chk("async_reset_paddr", bus.paddr, '0);
        @(posedge pclk); #3;
        preset = 1'b0;
        @(negedge pclk);
        chk("after_reset_cmd_ready", bus.cmd_ready, 1'b1);
        chk("after_reset_idle", {bus.psel, bus.rsp_valid}, 2'b00);
        q.push_back(mk(32'h24, 1'b0, 32'h0, 4'h0, 2, 1, 1'b0, 32'h0BAD_F00D, 1'b0));
        run_queue();

        // ACCESS with pready held low.
        @(posedge pclk); #1;
        drive_cmd(mk(32'h40, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0, 1'b0));
        bus.rsp_ready = 1'b0;
        @(posedge pclk); #1;
        garbage(1'b0);
        bus.pready  = 1'b0;
        bus.prdata  = 32'hFFFF_FFFF;
        bus.pslverr = 1'b0;
        @(negedge pclk);
        chk("to_setup", {bus.psel, bus.penable}, 2'b10);
        for (int k = 0; k < TO; k++) begin
            @(posedge pclk); #1;
            @(negedge pclk);
            chk("to_access", {bus.psel, bus.penable, bus.rsp_valid}, 3'b110);
        end
        @(posedge pclk); #1;
        @(negedge pclk);
`ifdef X2P_APB_TIMEOUT_EN
        chk("to_rsp_valid", bus.rsp_valid, 1'b1);
        chk("to_rsp_flags", {bus.rsp_slverr, bus.rsp_timeout}, 2'b11);
        chk("to_rsp_rdata", bus.rsp_rdata, '0);
        chk("to_psel", {bus.psel, bus.penable}, 2'b00);
        bus.rsp_ready = 1'b1;
        @(posedge pclk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge pclk);
        chk("to_consumed", bus.rsp_valid, 1'b0);
`else
        for (int k = 0; k < 20; k++) begin
            chk("no_to_psel", {bus.psel, bus.penable, bus.rsp_valid}, 3'b110);
            @(posedge pclk); #1;
            @(negedge pclk);
        end
        preset = 1'b1;
        #1;
        chk("no_to_reset", bus.psel, 1'b0);
        @(posedge pclk); #3;
        preset = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
